// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Multi-cycle HI/LO multiply/divide unit for a MIPS-style pipeline.
//
// The result of an accepted MULT/MULTU/DIV/DIVU is computed at the accepting
// edge and parked in a shadow register. The architectural HI/LO registers are
// not written until the busy window ends, so the pipeline sees a fixed latency.
// MTHI/MTLO write HI/LO directly when the unit is idle.
//
// Parameters
//   MULT_CYCLES : busy cycles for MULT/MULTU (>= 1)
//   DIV_CYCLES  : busy cycles for DIV/DIVU   (>= 1)
//
// Ports
//   clk   in   1  rising-edge clock
//   reset in   1  synchronous active-low reset
//   start in   1  one-cycle request qualifying op/A/B
//   op    in   3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   A     in  32  multiplicand / dividend / MTHI-MTLO source
//   B     in  32  multiplier / divisor
//   busy  out  1  high while a MULT/DIV is in flight (registered)
//   HI    out 32  architectural HI register
//   LO    out 32  architectural LO register
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [31:0]      hi_q,     hi_d;
    logic [31:0]      lo_q,     lo_d;
    logic [31:0]      res_hi_q, res_hi_d;
    logic [31:0]      res_lo_q, res_lo_d;
    logic             res_wr_q, res_wr_d;   // 0 for divide-by-zero: HI/LO left alone

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic signed [63:0] a_sx, b_sx, prod_s;
    logic        [63:0] prod_u;

    assign a_sx   = {{32{A[31]}}, A};
    assign b_sx   = {{32{B[31]}}, B};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, A} * {32'd0, B};

    // One unsigned divider serves both DIV and DIVU. Signed division works on
    // magnitudes and fixes the signs afterwards: quotient negative when the
    // operand signs differ, remainder follows the dividend. The magnitude of
    // 0x80000000 is 2^31 as an unsigned value, so 0x80000000 / -1 naturally
    // gives quotient 0x80000000, remainder 0.
    logic        div_signed;
    logic        a_neg, b_neg;
    logic [31:0] dvd, dvs, dvs_safe, quo_mag, rem_mag, quo, rem;

    assign div_signed = (op == OP_DIV);
    assign a_neg      = div_signed & A[31];
    assign b_neg      = div_signed & B[31];
    assign dvd        = a_neg ? (32'd0 - A) : A;
    assign dvs        = b_neg ? (32'd0 - B) : B;
    // A zero divisor never reaches HI/LO; substitute 1 so the divider never
    // produces X in simulation.
    assign dvs_safe   = (B == 32'd0) ? 32'd1 : dvs;
    assign quo_mag    = dvd / dvs_safe;
    assign rem_mag    = dvd % dvs_safe;
    assign quo        = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
    assign rem        = a_neg ? (32'd0 - rem_mag) : rem_mag;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default up front so no path through the
        // case/if structure leaves one unassigned, which would infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_wr_d = res_wr_q;

        if (state_q == S_IDLE) begin
            if (start) begin
                case (op)
                    OP_MULT, OP_MULTU: begin
                        {res_hi_d, res_lo_d} = (op == OP_MULT) ? prod_s : prod_u;
                        res_wr_d = 1'b1;
                        cnt_d    = CNT_W'(MULT_CYCLES);
                        state_d  = S_RUN;
                    end
                    OP_DIV, OP_DIVU: begin
                        res_hi_d = rem;
                        res_lo_d = quo;
                        res_wr_d = (B != 32'd0);
                        cnt_d    = CNT_W'(DIV_CYCLES);
                        state_d  = S_RUN;
                    end
                    OP_MTHI: hi_d = A;
                    OP_MTLO: lo_d = A;
                    default: ;  // 6-7: no-op
                endcase
            end
        end else begin
            // Any start seen here (including on the completing edge) is dropped.
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = S_IDLE;
                if (res_wr_q) begin
                    hi_d = res_hi_q;
                    lo_d = res_lo_q;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_wr_q <= res_wr_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy duration in cycles for MULT/MULTU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy duration in cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port start  input  1  one-cycle request qualifying op, A and B.
REQ-006 SHALL have port op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
REQ-007 SHALL have port A  input  32  operand 1: multiplicand, dividend, or MTHI/MTLO source (forwarded RD1).
REQ-008 SHALL have port B  input  32  operand 2: multiplier or divisor (forwarded RD2).
REQ-009 SHALL have port busy  output  1  high while an accepted MULT/DIV is in flight.
REQ-010 SHALL have port HI  output  32  architectural HI register.
REQ-011 SHALL have port LO  output  32  architectural LO register.

Function
REQ-012 SHALL use two states: IDLE (busy=0) and RUN (busy=1), plus a down-counter cnt sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-013 SHALL accept start only in IDLE; start in RUN is ignored and leaves state, counter, HI and LO unchanged.
REQ-014 On accepted MULT/MULTU, SHALL latch the 64-bit signed/unsigned product of A and B, load cnt=MULT_CYCLES and enter RUN at the same edge.
REQ-015 On accepted DIV/DIVU, SHALL latch quotient and remainder, load cnt=DIV_CYCLES and enter RUN at the same edge.
REQ-016 SHALL make busy high for exactly N consecutive cycles starting the cycle after the accepting edge (N = MULT_CYCLES or DIV_CYCLES).
REQ-017 SHALL decrement cnt by 1 each RUN cycle; the edge where cnt goes 1->0 SHALL write the latched result to HI/LO and return to IDLE.
REQ-018 SHALL keep HI/LO at their pre-operation values while busy=1; new values appear in the first cycle with busy=0.
REQ-019 Multiply SHALL set {HI,LO} = full 64-bit product; MULT uses two's-complement operands, MULTU unsigned.
REQ-020 Divide SHALL set LO = quotient and HI = remainder; DIV truncates toward zero and the remainder takes the sign of the dividend; DIVU is unsigned.
REQ-021 DIV with A=0x80000000 and B=0xFFFFFFFF SHALL yield LO=0x80000000 and HI=0x00000000.
REQ-022 DIV or DIVU with B=0 SHALL still run DIV_CYCLES with busy=1 and SHALL leave HI and LO unchanged at completion.
REQ-023 MTHI/MTLO accepted in IDLE SHALL write A to HI/LO at the accepting edge, with no busy cycle.
REQ-024 op 6-7 with start=1 SHALL be a no-op, with no state change.
REQ-025 start=1 in the same cycle as the completing edge SHALL be ignored, because the block is still in RUN; acceptance is possible from the next cycle.
REQ-026 HI, LO and busy SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-027 reset=0 at a rising edge SHALL clear HI=0, LO=0, busy=0 and cnt=0, and force IDLE.
REQ-028 Reset during RUN SHALL discard the pending result; HI/LO remain 0 after reset releases.
REQ-029 reset=0 SHALL take priority over start in the same cycle.

Verification
REQ-030 MULT A=0xFFFFFFFE, B=0x00000003 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-032 DIV A=0xFFFFFFF9 (-7), B=2 -> busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7, B=0 -> after 10 busy cycles, HI/LO unchanged.
REQ-033 MTLO A=0x12345678 in IDLE -> LO=0x12345678 next cycle with busy never high; MTHI issued while busy -> HI unaffected.
REQ-034 reset=0 applied in busy cycle 3 of a MULT -> next cycle busy=0, HI=LO=0; a new MULT 3x4 then gives LO=12 after 5 cycles.
REQ-035 start DIV in the completing cycle of a MULT -> ignored; busy=0 in the next cycle and HI/LO hold the MULT result.
